// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: up to IN_WIDTH pushes and OUT_WIDTH pops per cycle,
// with a single-cycle flush for commit redirects. Storage is left unreset; only pointers and count clear.
module fetch_queue #(
   parameter int DEPTH     = 8,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int ENTRY_W   = 72
) (
   input  logic                             clk_i,
   input  logic                             reset_ni,
   input  logic                             flush_i,
   input  logic [IN_WIDTH-1:0]              in_valid_i,
   input  logic [IN_WIDTH*ENTRY_W-1:0]      in_data_i,
   output logic                             in_ready_o,
   output logic [OUT_WIDTH-1:0]             out_valid_o,
   output logic [OUT_WIDTH*ENTRY_W-1:0]     out_data_o,
   input  logic [$clog2(OUT_WIDTH+1)-1:0]   out_pop_i,
   output logic [$clog2(DEPTH):0]           count_o,
   output logic                             empty_o,
   output logic                             full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [CNT_W-1:0] npush;
   logic [CNT_W-1:0] npush_acc;
   logic [CNT_W-1:0] npop;
   logic             in_ready;
   logic             lead;

   logic [IN_WIDTH-1:0] wr_en;
   logic [PTR_W-1:0]    wr_idx [IN_WIDTH];
   logic [PTR_W-1:0]    rd_idx;

   // Only the contiguous run of valid lanes starting at lane 0 is taken.
   always_comb begin
      npush = '0;
      lead  = 1'b1;
      for (int k = 0; k < IN_WIDTH; k++) begin
         lead = lead & in_valid_i[k];
         if (lead) npush = npush + CNT_W'(1);
      end
   end

   // Depends on registered count only, so a same-cycle pop never opens the gate.
   assign in_ready = (count_q <= CNT_W'(DEPTH - IN_WIDTH));

   always_comb begin
      npop = CNT_W'(out_pop_i);
      if (npop > CNT_W'(OUT_WIDTH)) npop = CNT_W'(OUT_WIDTH);
      if (npop > count_q)           npop = count_q;
   end

   assign npush_acc = in_ready ? npush : '0;

   always_comb begin
      head_d  = head_q + PTR_W'(npop);
      tail_d  = tail_q + PTR_W'(npush_acc);
      count_d = count_q + npush_acc - npop;
   end

   always_comb begin
      wr_en = '0;
      for (int k = 0; k < IN_WIDTH; k++) begin
         wr_idx[k] = tail_q + PTR_W'(k);
         wr_en[k]  = reset_ni && !flush_i && in_ready && (CNT_W'(k) < npush);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < IN_WIDTH; k++) begin
         if (wr_en[k]) mem_q[wr_idx[k]] <= in_data_i[k*ENTRY_W +: ENTRY_W];
      end
   end

   always_comb begin
      out_valid_o = '0;
      out_data_o  = '0;
      rd_idx      = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         rd_idx         = head_q + PTR_W'(i);
         out_valid_o[i] = (count_q > CNT_W'(i));
         out_data_o[i*ENTRY_W +: ENTRY_W] = mem_q[rd_idx];
      end
   end

   assign in_ready_o = in_ready;
   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2.
module tb_fetch_queue;

   localparam int EW = 72;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush;
   logic [1:0]    in_valid;
   logic [2*EW-1:0] in_data;
   logic          in_ready;
   logic [1:0]    out_valid;
   logic [2*EW-1:0] out_data;
   logic [1:0]    out_pop;
   logic [3:0]    count;
   logic          empty;
   logic          full;

   int checks   = 0;
   int failures = 0;
   int contig_viol = 0;

   fetch_queue #(.DEPTH(8), .IN_WIDTH(2), .OUT_WIDTH(2), .ENTRY_W(EW)) dut (
      .clk_i(clk), .reset_ni(reset_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_pop_i(out_pop),
      .count_o(count), .empty_o(empty), .full_o(full)
   );

   always #5 clk = ~clk;

   // in_valid must be a contiguous run from lane 0
   always @(negedge clk) begin
      if (reset_n === 1'b1 && in_valid === 2'b10) contig_viol++;
   end

   function automatic logic [EW-1:0] pkt(input int t);
      logic [7:0] t8;
      t8 = t[7:0];
      return {t8, 64'h0123_4567_89AB_CDEF ^ {56'h0, t8}};
   endfunction

   task automatic drive(input logic [1:0] v, input int t0, input int t1, input logic [1:0] pop);
      in_valid = v;
      in_data  = {pkt(t1), pkt(t0)};
      out_pop  = pop;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      drive(2'b00, 0, 0, 2'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      flush   = 1'b0;
      drive(2'b00, 0, 0, 2'd0);
      for (int c = 0; c < 6; c++) begin
         if (c == 3) reset_n = 1'b1;
         tick();
         if ({count, empty, full, in_ready, out_valid} !== {4'd0, 1'b1, 1'b0, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got cnt=%0d e=%b f=%b r=%b ov=%b exp cnt=0 e=1 f=0 r=1 ov=00",
                     c, count, empty, full, in_ready, out_valid);
         end
         checks++;
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready i=%0d got=%b exp=1", i, in_ready); end
         checks++;
         drive(2'b11, 2*i+1, 2*i+2, 2'd0);
         tick();
         if (count !== 4'(2*(i+1))) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, 2*(i+1)); end
         checks++;
      end
      if ({full, in_ready, out_valid} !== 4'b1011) begin
         failures++; $display("FAIL fill_full got f=%b r=%b ov=%b exp f=1 r=0 ov=11", full, in_ready, out_valid);
      end
      checks++;
      if (out_data !== {pkt(2), pkt(1)}) begin failures++; $display("FAIL fill_order got=%h exp=%h", out_data, {pkt(2), pkt(1)}); end
      checks++;
      // full: push rejected even though one entry leaves this cycle
      drive(2'b11, 9, 10, 2'd1);
      tick();
      if ({count, full, in_ready} !== {4'd7, 1'b0, 1'b0}) begin
         failures++; $display("FAIL fill_pop1 got cnt=%0d f=%b r=%b exp cnt=7 f=0 r=0", count, full, in_ready);
      end
      checks++;
      drive(2'b11, 9, 10, 2'd0);
      tick();
      if (count !== 4'd7 || out_data !== {pkt(3), pkt(2)}) begin
         failures++; $display("FAIL fill_at7 got cnt=%0d data=%h exp cnt=7 data=%h", count, out_data, {pkt(3), pkt(2)});
      end
      checks++;
      do_flush();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 'h11+2*i, 'h12+2*i, 2'd0);
         tick();
      end
      for (int j = 0; j < 3; j++) begin
         if (out_data[EW-1:0] !== pkt('h11+2*j)) begin
            failures++; $display("FAIL wrap_pre_pop j=%0d got=%h exp=%h", j, out_data[EW-1:0], pkt('h11+2*j));
         end
         checks++;
         drive(2'b00, 0, 0, 2'd2);
         tick();
      end
      if (count !== 4'd0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", count); end
      checks++;
      drive(2'b11, 'hA, 'hB, 2'd0);
      tick();
      drive(2'b11, 'hC, 'hD, 2'd0);
      tick();
      drive(2'b00, 0, 0, 2'd0);
      if (count !== 4'd4 || out_data !== {pkt('hB), pkt('hA)}) begin
         failures++; $display("FAIL wrap_head got cnt=%0d data=%h exp cnt=4 data=%h", count, out_data, {pkt('hB), pkt('hA)});
      end
      checks++;
      if (dut.mem_q[6] !== pkt('hA) || dut.mem_q[7] !== pkt('hB) || dut.mem_q[0] !== pkt('hC) || dut.mem_q[1] !== pkt('hD)) begin
         failures++; $display("FAIL wrap_slots got s6=%h s7=%h s0=%h s1=%h exp A,B,C,D",
                              dut.mem_q[6], dut.mem_q[7], dut.mem_q[0], dut.mem_q[1]);
      end
      checks++;
      drive(2'b00, 0, 0, 2'd2);
      tick();
      if (count !== 4'd2 || out_data !== {pkt('hD), pkt('hC)}) begin
         failures++; $display("FAIL wrap_tail got cnt=%0d data=%h exp cnt=2 data=%h", count, out_data, {pkt('hD), pkt('hC)});
      end
      checks++;
      tick();
      if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got cnt=%0d e=%b exp 0/1", count, empty); end
      checks++;
      do_flush();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 'h21+2*i, 'h22+2*i, 2'd0);
         tick();
      end
      // full: push rejected, pop of 2 proceeds
      drive(2'b11, 'h31, 'h32, 2'd2);
      tick();
      if (count !== 4'd6 || out_data !== {pkt('h24), pkt('h23)}) begin
         failures++; $display("FAIL b2b_at8 got cnt=%0d data=%h exp cnt=6 data=%h", count, out_data, {pkt('h24), pkt('h23)});
      end
      checks++;
      // count 6 leaves room for a full burst, so push and pop both happen
      drive(2'b11, 'h33, 'h34, 2'd2);
      tick();
      if (count !== 4'd6 || out_data !== {pkt('h26), pkt('h25)}) begin
         failures++; $display("FAIL b2b_at6 got cnt=%0d data=%h exp cnt=6 data=%h", count, out_data, {pkt('h26), pkt('h25)});
      end
      checks++;
      drive(2'b00, 0, 0, 2'd2);
      tick();
      drive(2'b11, 'h35, 'h36, 2'd2);
      tick();
      if (count !== 4'd4 || out_data !== {pkt('h34), pkt('h33)}) begin
         failures++; $display("FAIL b2b_at4 got cnt=%0d data=%h exp cnt=4 data=%h", count, out_data, {pkt('h34), pkt('h33)});
      end
      checks++;
      drive(2'b00, 0, 0, 2'd2);
      tick();
      if (count !== 4'd2 || out_data !== {pkt('h36), pkt('h35)}) begin
         failures++; $display("FAIL b2b_order got cnt=%0d data=%h exp cnt=2 data=%h", count, out_data, {pkt('h36), pkt('h35)});
      end
      checks++;
      do_flush();
   endtask

   task automatic test_flush();
      drive(2'b11, 'h41, 'h42, 2'd0); tick();
      drive(2'b11, 'h43, 'h44, 2'd0); tick();
      drive(2'b01, 'h45, 'h46, 2'd0); tick();
      if (count !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", count); end
      checks++;
      drive(2'b11, 'h47, 'h48, 2'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(2'b00, 0, 0, 2'd0);
      if ({count, empty, out_valid} !== {4'd0, 1'b1, 2'b00}) begin
         failures++; $display("FAIL flush_clear got cnt=%0d e=%b ov=%b exp 0/1/00", count, empty, out_valid);
      end
      checks++;
      drive(2'b11, 'h49, 'h4A, 2'd0);
      tick();
      if (count !== 4'd2 || out_data !== {pkt('h4A), pkt('h49)}) begin
         failures++; $display("FAIL flush_after got cnt=%0d data=%h exp cnt=2 data=%h", count, out_data, {pkt('h4A), pkt('h49)});
      end
      checks++;
      do_flush();
   endtask

   task automatic test_clamp();
      drive(2'b01, 'h51, 0, 2'd0); tick();
      drive(2'b00, 0, 0, 2'd2);    tick();
      if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL clamp_count got cnt=%0d e=%b exp 0/1", count, empty); end
      checks++;
      // empty with a pop request: only the push lands
      drive(2'b11, 'h52, 'h53, 2'd2); tick();
      if (count !== 4'd2 || out_data[EW-1:0] !== pkt('h52)) begin
         failures++; $display("FAIL clamp_empty_pop got cnt=%0d d0=%h exp cnt=2 d0=%h", count, out_data[EW-1:0], pkt('h52));
      end
      checks++;
      drive(2'b01, 'h54, 0, 2'd0); tick();
      drive(2'b00, 0, 0, 2'd3);    tick();
      if (count !== 4'd1 || out_data[EW-1:0] !== pkt('h54)) begin
         failures++; $display("FAIL clamp_width got cnt=%0d d0=%h exp cnt=1 d0=%h", count, out_data[EW-1:0], pkt('h54));
      end
      checks++;
      if (contig_viol !== 0) begin failures++; $display("FAIL contig_none got=%0d exp=0", contig_viol); end
      checks++;
      drive(2'b10, 'h60, 'h61, 2'd0); tick();
      drive(2'b00, 0, 0, 2'd0);
      if (count !== 4'd1 || out_data[EW-1:0] !== pkt('h54)) begin
         failures++; $display("FAIL noncontig_push got cnt=%0d d0=%h exp cnt=1 d0=%h", count, out_data[EW-1:0], pkt('h54));
      end
      checks++;
      @(negedge clk);
      if (contig_viol !== 1) begin failures++; $display("FAIL contig_fired got=%0d exp=1", contig_viol); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_clamp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
